// File: rtl/inv_row_dwt97.sv
// Inverse 9/7 row lifting: {high,low} pairs in, {odd,even} pairs out, 2-pair latency plus end-of-line flush.
// Define INV_ROW_DWT97_SATURATE_EN to saturate stage results; otherwise they wrap to DataWidth.
module inv_row_dwt97 #(
  parameter int DataWidth       = 16,
  parameter int Point           = 10,
  parameter int MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);
  localparam int  PW    = DataWidth + Point + 8;
  localparam int  CW    = $clog2(MaximumSideSize / 2) + 1;
  localparam real SCALE = real'(1 << Point);

  typedef logic signed [DataWidth-1:0] smp_t;
  typedef logic signed [PW-1:0]        wide_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  localparam wide_t CK   = wide_t'(int'(1.230174105 * SCALE));
  localparam wide_t CIK  = wide_t'(int'(SCALE / 1.230174105));
  localparam wide_t CD   = wide_t'(int'(0.443506852 * SCALE));
  localparam wide_t CG   = wide_t'(int'(0.882911076 * SCALE));
  localparam wide_t CB   = wide_t'(int'(-0.052980118 * SCALE));
  localparam wide_t CA   = wide_t'(int'(-1.586134342 * SCALE));
  localparam wide_t HALF = wide_t'(1) <<< (Point - 1);

  function automatic smp_t sat_dw(input wide_t v);
    if (&v[PW-1:DataWidth-1] || ~|v[PW-1:DataWidth-1]) return v[DataWidth-1:0];
    return v[PW-1] ? {1'b1, {(DataWidth-1){1'b0}}} : {1'b0, {(DataWidth-1){1'b1}}};
  endfunction

  function automatic smp_t rnd_prod(input wide_t p);
    wide_t r;
    r = (p + HALF) >>> Point;
    return sat_dw(r);
  endfunction

  // x - round(c * (a + b)); the operand sum is exact before the multiply
  function automatic smp_t lift(input smp_t x, input smp_t a, input smp_t b, input wide_t c);
    wide_t sum;
    smp_t  p;
    sum = wide_t'(a) + wide_t'(b);
    p   = rnd_prod(sum * c);
`ifdef INV_ROW_DWT97_SATURATE_EN
    return sat_dw(wide_t'(x) - wide_t'(p));
`else
    return x - p;
`endif
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sof_cur, sof_nxt;
  smp_t          o0_p, e1_p, o1_pp, e2_pp;

  logic en, flushing, take, inj, beat, emit;
  smp_t lo, hi, e0, o0, o0_prev, e1_n, o1_m1, o1_m2, e2_m1, e2_nx, o2;

  assign en        = ~m_valid_o | m_ready_i;
  assign flushing  = (state == FLUSH1) || (state == FLUSH2);
  assign s_ready_o = en & ~flushing & ~rst_i;
  assign take      = s_valid_i & s_ready_o;
  assign inj       = en & flushing;
  assign beat      = take | inj;
  assign emit      = cnt >= CW'(2);

  // Beat j yields e1[j], o1[j-1], e2[j-1] and the final pair j-2.
  always_comb begin
    lo      = s_data_i[DataWidth-1:0];
    hi      = s_data_i[2*DataWidth-1:DataWidth];
    e0      = inj ? '0 : rnd_prod(wide_t'(lo) * CK);
    o0      = inj ? '0 : rnd_prod(wide_t'(hi) * CIK);
    o0_prev = (cnt == '0) ? o0 : o0_p;
    e1_n    = inj ? e1_p : lift(e0, o0_prev, o0, CD);
    o1_m1   = lift(o0_p, e1_p, e1_n, CG);
    o1_m2   = (cnt == CW'(1)) ? o1_m1 : o1_pp;
    e2_m1   = lift(e1_p, o1_m2, o1_m1, CB);
    e2_nx   = (state == FLUSH2) ? e2_pp : e2_m1;
    o2      = lift(o1_pp, e2_pp, e2_nx, CA);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      sof_cur   <= 1'b0;
      sof_nxt   <= 1'b0;
      o0_p      <= '0;
      e1_p      <= '0;
      o1_pp     <= '0;
      e2_pp     <= '0;
      m_valid_o <= 1'b0;
      m_sof_o   <= 1'b0;
      m_eol_o   <= 1'b0;
      m_data_o  <= '0;
    end else if (en) begin
      if (beat) begin
        o0_p      <= o0;
        e1_p      <= e1_n;
        o1_pp     <= o1_m1;
        e2_pp     <= e2_m1;
        cnt       <= (state == FLUSH2) ? '0 : cnt + CW'(1);
        m_valid_o <= emit;
        m_sof_o   <= emit && (cnt == CW'(2)) && sof_cur;
        m_eol_o   <= emit && (state == FLUSH2);
        if (emit) m_data_o <= {o2, e2_pp};
        if (emit && cnt == CW'(2)) sof_cur <= 1'b0;
      end else begin
        m_valid_o <= 1'b0;
        m_sof_o   <= 1'b0;
        m_eol_o   <= 1'b0;
      end
      // A frame start seen mid-line is deferred to the next line's first output
      if (take) begin
        if (cnt == '0) begin
          sof_cur <= s_sof_i | sof_nxt;
          sof_nxt <= 1'b0;
        end else if (s_sof_i) begin
          sof_nxt <= 1'b1;
        end
      end
      case (state)
        IDLE:    if (take) state <= s_eol_i ? FLUSH1 : RUN;
        RUN:     if (take && s_eol_i) state <= FLUSH1;
        FLUSH1:  state <= FLUSH2;
        FLUSH2:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_row_dwt97.sv
// Randomized bench for inv_row_dwt97: whole-line integer lifting model, queue scoreboard, stall and reset checks.
module tb_inv_row_dwt97;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_ready;
  logic        s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b1;
  logic        m_valid, m_sof, m_eol;
  logic [31:0] m_data;

  int checks = 0, failures = 0;
  int rmode = 0;
  bit carry = 0;

  always #5 clk = ~clk;

  inv_row_dwt97 #(.DataWidth(16), .Point(10), .MaximumSideSize(512)) dut (
    .clk_i(clk), .rst_i(rst), .s_ready_o(s_ready), .s_valid_i(s_valid),
    .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready),
    .m_valid_o(m_valid), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_data_o(m_data)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Coefficients quantised at Point=10
  localparam int CK = 1260, CIK = 832, CD = 454, CG = 904, CB = -54, CA = -1624;
  int lin[16], hin[16], xo[16], xe[16];

  function automatic int rsat(input longint p);
    longint r;
    r = (p + 512) >>> 10;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic int fit(input int d);
`ifdef INV_ROW_DWT97_SATURATE_EN
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
`else
    return int'(shortint'(d));
`endif
  endfunction

  function automatic int lift(input int x, input int a, input int b, input int c);
    return fit(x - rsat(longint'(a + b) * c));
  endfunction

  task automatic model(input int n);
    int e0[16], o0[16], e1[16], o1[16];
    for (int i = 0; i < n; i++) begin
      e0[i] = rsat(longint'(lin[i]) * CK);
      o0[i] = rsat(longint'(hin[i]) * CIK);
    end
    for (int i = 0; i < n; i++) e1[i] = lift(e0[i], o0[(i == 0) ? 0 : i - 1], o0[i], CD);
    for (int i = 0; i < n; i++) o1[i] = lift(o0[i], e1[i], e1[(i == n - 1) ? i : i + 1], CG);
    for (int i = 0; i < n; i++) xe[i] = lift(e1[i], o1[(i == 0) ? 0 : i - 1], o1[i], CB);
    for (int i = 0; i < n; i++) xo[i] = lift(o1[i], xe[i], xe[(i == n - 1) ? i : i + 1], CA);
  endtask

  typedef struct { int odd; int even; bit sof; bit eol; } exp_t;
  exp_t expq[$];
  exp_t cur;
  logic [31:0] exp_d, held_d;
  logic [1:0]  held_f;
  bit          stalled = 0;

  // Scoreboard on every transfer; stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled)
        chk(m_valid && m_data == held_d && {m_sof, m_eol} == held_f, "stall_hold",
            longint'(m_data), longint'(held_d));
      stalled = m_valid && !m_ready;
      held_d  = m_data;
      held_f  = {m_sof, m_eol};
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_out", longint'(m_data), 0);
        end else begin
          cur   = expq.pop_front();
          exp_d = {cur.odd[15:0], cur.even[15:0]};
          chk(m_data == exp_d, "out_data", longint'(m_data), longint'(exp_d));
          chk({m_sof, m_eol} == {cur.sof, cur.eol}, "out_flags",
              longint'({m_sof, m_eol}), longint'({cur.sof, cur.eol}));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  task automatic put_beat(input int l, input int h, input bit sof, input bit eol);
    logic [15:0] lv, hv;
    bit ok;
    lv = l[15:0];
    hv = h[15:0];
    s_valid = 1'b1; s_data = {hv, lv}; s_sof = sof; s_eol = eol; ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    if (!ok) chk(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic send_line(input int n, input int sof_pos, input bit gaps, input bit dead_chk);
    exp_t x;
    model(n);
    for (int i = 0; i < n; i++) begin
      x.odd = xo[i]; x.even = xe[i];
      x.sof = (i == 0) && (sof_pos == 0 || carry);
      x.eol = (i == n - 1);
      expq.push_back(x);
    end
    carry = (sof_pos > 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      put_beat(lin[i], hin[i], i == sof_pos, i == n - 1);
    end
    if (dead_chk) begin
      @(negedge clk); chk(s_ready == 1'b0, "dead_cycle1", longint'(s_ready), 0);
      @(posedge clk); #1;
      @(negedge clk); chk(s_ready == 1'b0, "dead_cycle2", longint'(s_ready), 0);
      @(posedge clk); #1;
      @(negedge clk); chk(s_ready == 1'b1, "ready_after_flush", longint'(s_ready), 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && expq.size() > 0; t++) @(negedge clk);
    chk(expq.size() == 0, "drain", longint'(expq.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int rval(input bit big);
    if (big) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  task automatic fill(input int n, input bit big);
    for (int i = 0; i < n; i++) begin
      lin[i] = rval(big);
      hin[i] = rval(big);
    end
  endtask

  initial begin
    // Pin the model against hand-derived values
    lin[0] = 100; hin[0] = 0; model(1);
    chk(xo[0] == 100, "pin_dc_odd", xo[0], 100);
    chk(xe[0] == 100, "pin_dc_even", xe[0], 100);
    lin[0] = 0; hin[0] = 100; model(1);
    chk(xo[0] == 49, "pin_hf_odd", xo[0], 49);
    chk(xe[0] == -50, "pin_hf_even", xe[0], -50);

    repeat (2) @(negedge clk);
    chk({m_valid, m_sof, m_eol, s_ready} == 4'b0 && m_data == '0, "reset_state",
        longint'({m_valid, m_sof, m_eol, s_ready}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk(s_ready == 1'b1, "ready_after_reset", longint'(s_ready), 1);
    @(posedge clk); #1;

    // All-zero N=4 line with the flush gap observed
    for (int i = 0; i < 4; i++) begin lin[i] = 0; hin[i] = 0; end
    send_line(4, 0, 0, 1);
    // N=1 lines
    lin[0] = 100; hin[0] = 0; send_line(1, 0, 0, 0);
    lin[0] = 0; hin[0] = 100; send_line(1, 0, 0, 0);
    drain();

    // Same N=8 line without and with alternating backpressure
    fill(8, 0);
    send_line(8, 0, 0, 0);
    drain();
    rmode = 1;
    send_line(8, 0, 0, 0);
    drain();
    rmode = 0;

    // Full-scale inputs exercise saturation or wrap
    for (int i = 0; i < 4; i++) begin lin[i] = 32767; hin[i] = 32767; end
    send_line(4, 0, 0, 0);
    // Mid-line frame start carries to the following line
    fill(4, 0); send_line(4, 2, 0, 0);
    fill(3, 0); send_line(3, -1, 0, 0);
    drain();

    for (int k = 0; k < 25; k++) begin
      rmode = $urandom_range(0, 2);
      fill(16, $urandom_range(0, 1) == 1);
      send_line($urandom_range(1, 8), ($urandom_range(0, 3) == 0) ? 0 : -1, 1, 0);
    end
    rmode = 0;
    drain();

    // Asynchronous reset mid-line with the output stalled
    rmode = 3;
    repeat (2) @(posedge clk);
    #1;
    fill(8, 0);
    for (int i = 0; i < 3; i++) put_beat(lin[i], hin[i], i == 0, 1'b0);
    @(negedge clk);
    chk(m_valid == 1'b1, "pre_reset_valid", longint'(m_valid), 1);
    #2 rst = 1'b1;
    #1 chk({m_valid, m_sof, m_eol, s_ready} == 4'b0 && m_data == '0, "async_reset_clear",
           longint'({m_valid, m_sof, m_eol, s_ready}), 0);
    carry = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rmode = 0;
    @(negedge clk);
    chk(s_ready == 1'b1, "ready_after_midline_reset", longint'(s_ready), 1);
    @(posedge clk); #1;
    fill(4, 0);
    send_line(4, -1, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
